// File: rtl/reg_file_mp_if.sv
// Bus bundle for the multi-port register file: writeback lanes, read ports,
// issue/flush scoreboard controls and the idle status.
interface reg_file_mp_if #(
    parameter int DW  = 32,
    parameter int RAW = 5,
    parameter int NR  = 2,
    parameter int NW  = 2
) ();
    logic [NW-1:0]     i_write_en;
    logic [NW*RAW-1:0] i_write_reg;
    logic [NW*DW-1:0]  i_write_data;
    logic [NR-1:0]     i_read_en;
    logic [NR*RAW-1:0] i_read_reg;
    logic [NR*DW-1:0]  o_read_data;
    logic [NR-1:0]     o_read_busy;
    logic              i_issue_en;
    logic [RAW-1:0]    i_issue_reg;
    logic              i_flush;
    logic              o_idle;

    modport master (
        output i_write_en, i_write_reg, i_write_data,
        output i_read_en, i_read_reg,
        output i_issue_en, i_issue_reg, i_flush,
        input  o_read_data, o_read_busy, o_idle
    );

    modport slave (
        input  i_write_en, i_write_reg, i_write_data,
        input  i_read_en, i_read_reg,
        input  i_issue_en, i_issue_reg, i_flush,
        output o_read_data, o_read_busy, o_idle
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register busy scoreboard used by decode for RAW-hazard stalls.
module reg_file_mp #(
    parameter int DW       = 32,
    parameter int RAW      = 5,
    parameter int NR       = 2,
    parameter int NW       = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input logic          clk,
    input logic          rst,
    reg_file_mp_if.slave bus
);
    localparam int DP = 2**RAW;

    logic [RAW-1:0] wrAddr [NW];
    logic [DW-1:0]  wrData [NW];
    logic [NW-1:0]  wrHit;
    logic [RAW-1:0] rdAddr [NR];
    logic [DW-1:0]  rdData [NR];
    logic [NR-1:0]  rdBusy;

    logic [DW-1:0]  regFile_q [DP];
    logic [DW-1:0]  regFile_d [DP];
    logic [DP-1:0]  busy_q;
    logic [DP-1:0]  busy_d;

    function automatic logic isZero(input logic [RAW-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    for (genvar k = 0; k < NW; k++) begin : g_lane
        assign wrAddr[k] = bus.i_write_reg[k*RAW +: RAW];
        assign wrData[k] = bus.i_write_data[k*DW +: DW];
        assign wrHit[k]  = bus.i_write_en[k] && !isZero(wrAddr[k]);
    end

    for (genvar p = 0; p < NR; p++) begin : g_port
        assign rdAddr[p]                      = bus.i_read_reg[p*RAW +: RAW];
        assign bus.o_read_data[p*DW +: DW]    = rdData[p];
    end

    // Lanes are walked in ascending order so the highest lane wins a collision;
    // flush then issue come after writeback so a fresh producer stays pending.
    always_comb begin
        regFile_d = regFile_q;
        busy_d    = busy_q;
        for (int k = 0; k < NW; k++) begin
            if (wrHit[k]) begin
                regFile_d[wrAddr[k]] = wrData[k];
                busy_d[wrAddr[k]]    = 1'b0;
            end
        end
        if (bus.i_flush) begin
            busy_d = '0;
        end
        if (bus.i_issue_en && !isZero(bus.i_issue_reg)) begin
            busy_d[bus.i_issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DP; i++) begin
                regFile_q[i] <= '0;
            end
            busy_q <= '0;
        end else begin
            regFile_q <= regFile_d;
            busy_q    <= busy_d;
        end
    end

    // Reads are gated by rst so a same-cycle bypass cannot leak data during reset.
    always_comb begin
        for (int p = 0; p < NR; p++) begin
            rdData[p] = '0;
            rdBusy[p] = 1'b0;
            if (!rst && bus.i_read_en[p] && !isZero(rdAddr[p])) begin
                rdData[p] = regFile_q[rdAddr[p]];
                rdBusy[p] = busy_q[rdAddr[p]];
                if (BYPASS != 0) begin
                    for (int k = 0; k < NW; k++) begin
                        if (bus.i_write_en[k] && (wrAddr[k] == rdAddr[p])) begin
                            rdData[p] = wrData[k];
                            rdBusy[p] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign bus.o_read_busy = rdBusy;
    assign bus.o_idle      = rst || (busy_q == '0);
endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench driving a bypassing and a non-bypassing register file with
// identical stimulus and checking both against a behavioural array model.
module tb_reg_file_mp;
    localparam int DW  = 32;
    localparam int RAW = 5;
    localparam int NR  = 2;
    localparam int NW  = 2;
    localparam int DP  = 2**RAW;

    typedef struct {
        int              port;
        logic [DW-1:0]   dB;
        logic [DW-1:0]   dN;
        logic            bB;
        logic            bN;
        logic            idle;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tbRst = 1'b1;

    int vectors = 0;
    int miscompares = 0;

    exp_t expQ[$];

    logic [DW-1:0] mMem [DP];
    logic [DP-1:0] mBusy = '0;

    logic [NW-1:0]     rWe;
    logic [NW*RAW-1:0] rWreg;
    logic [NW*DW-1:0]  rWdata;
    logic [NR-1:0]     rRe;
    logic [NR*RAW-1:0] rRreg;
    logic              rIss;
    logic [RAW-1:0]    rIssReg;
    logic              rFlush;

    reg_file_mp_if #(.DW(DW), .RAW(RAW), .NR(NR), .NW(NW)) busB ();
    reg_file_mp_if #(.DW(DW), .RAW(RAW), .NR(NR), .NW(NW)) busN ();

    reg_file_mp #(.DW(DW), .RAW(RAW), .NR(NR), .NW(NW), .BYPASS(1), .ZERO_REG(1))
        dutB (.clk(clk), .rst(rst), .bus(busB));
    reg_file_mp #(.DW(DW), .RAW(RAW), .NR(NR), .NW(NW), .BYPASS(0), .ZERO_REG(1))
        dutN (.clk(clk), .rst(rst), .bus(busN));

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One cycle of stimulus: drive both DUTs, queue the expected outputs, then
    // advance the model to the state the coming clock edge should produce.
    task automatic applyStimulus(
        input logic [NW-1:0]     we,
        input logic [NW*RAW-1:0] wreg,
        input logic [NW*DW-1:0]  wdata,
        input logic [NR-1:0]     re,
        input logic [NR*RAW-1:0] rreg,
        input logic              issEn,
        input logic [RAW-1:0]    issReg,
        input logic              flush
    );
        exp_t e;
        logic [RAW-1:0] a;
        logic [RAW-1:0] w;
        @(posedge clk);
        #1;
        rst = tbRst;
        busB.i_write_en = we;  busB.i_write_reg = wreg;  busB.i_write_data = wdata;
        busB.i_read_en  = re;  busB.i_read_reg  = rreg;
        busB.i_issue_en = issEn; busB.i_issue_reg = issReg; busB.i_flush = flush;
        busN.i_write_en = we;  busN.i_write_reg = wreg;  busN.i_write_data = wdata;
        busN.i_read_en  = re;  busN.i_read_reg  = rreg;
        busN.i_issue_en = issEn; busN.i_issue_reg = issReg; busN.i_flush = flush;

        e.port = -1; e.dB = '0; e.dN = '0; e.bB = 1'b0; e.bN = 1'b0;
        e.idle = tbRst ? 1'b1 : (mBusy == '0);
        expQ.push_back(e);

        for (int p = 0; p < NR; p++) begin
            if (re[p]) begin
                a = rreg[p*RAW +: RAW];
                e.port = p; e.dB = '0; e.dN = '0; e.bB = 1'b0; e.bN = 1'b0; e.idle = 1'b0;
                if (!tbRst && a != 0) begin
                    e.dN = mMem[a];
                    e.bN = mBusy[a];
                    e.dB = mMem[a];
                    e.bB = mBusy[a];
                    for (int k = NW-1; k >= 0; k--) begin
                        if (we[k] && wreg[k*RAW +: RAW] == a) begin
                            e.dB = wdata[k*DW +: DW];
                            e.bB = 1'b0;
                            break;
                        end
                    end
                end
                expQ.push_back(e);
            end
        end

        if (tbRst) begin
            for (int i = 0; i < DP; i++) mMem[i] = '0;
            mBusy = '0;
        end else begin
            for (int k = 0; k < NW; k++) begin
                w = wreg[k*RAW +: RAW];
                if (we[k] && w != 0) begin
                    mMem[w]  = wdata[k*DW +: DW];
                    mBusy[w] = 1'b0;
                end
            end
            if (flush) mBusy = '0;
            if (issEn && issReg != 0) mBusy[issReg] = 1'b1;
        end
    endtask

    function automatic logic [RAW-1:0] randReg();
        if ($urandom_range(0, 3) == 0) return RAW'($urandom_range(0, DP-1));
        return RAW'($urandom_range(0, 7));
    endfunction

    always begin
        exp_t e;
        @(negedge clk);
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput("cycleAlign", 64'(e.port), 64'(-1));
            checkOutput("idleB", 64'(busB.o_idle), 64'(e.idle));
            checkOutput("idleN", 64'(busN.o_idle), 64'(e.idle));
            for (int p = 0; p < NR; p++) begin
                if (busB.i_read_en[p]) begin
                    if (expQ.size() == 0) begin
                        checkOutput("missingExpect", 64'(p), 64'(-1));
                    end else begin
                        e = expQ.pop_front();
                        checkOutput($sformatf("portAlign%0d", p), 64'(e.port), 64'(p));
                        checkOutput($sformatf("dataB_p%0d", p), 64'(busB.o_read_data[p*DW +: DW]), 64'(e.dB));
                        checkOutput($sformatf("busyB_p%0d", p), 64'(busB.o_read_busy[p]), 64'(e.bB));
                        checkOutput($sformatf("dataN_p%0d", p), 64'(busN.o_read_data[p*DW +: DW]), 64'(e.dN));
                        checkOutput($sformatf("busyN_p%0d", p), 64'(busN.o_read_busy[p]), 64'(e.bN));
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < DP; i++) mMem[i] = '0;
        busB.i_write_en = '0; busB.i_write_reg = '0; busB.i_write_data = '0;
        busB.i_read_en = '0;  busB.i_read_reg = '0;
        busB.i_issue_en = 1'b0; busB.i_issue_reg = '0; busB.i_flush = 1'b0;
        busN.i_write_en = '0; busN.i_write_reg = '0; busN.i_write_data = '0;
        busN.i_read_en = '0;  busN.i_read_reg = '0;
        busN.i_issue_en = 1'b0; busN.i_issue_reg = '0; busN.i_flush = 1'b0;

        tbRst = 1'b1;
        applyStimulus(2'b00, '0, '0, 2'b11, {5'd3, 5'd0}, 1'b0, 5'd0, 1'b0);
        applyStimulus(2'b00, '0, '0, 2'b01, {5'd0, 5'd5}, 1'b0, 5'd0, 1'b0);
        tbRst = 1'b0;

        // x5 written, read back, then wiped by an asynchronous reset
        applyStimulus(2'b01, {5'd0, 5'd5}, {32'h0, 32'hDEADBEEF}, 2'b00, '0, 1'b0, 5'd0, 1'b0);
        applyStimulus(2'b00, '0, '0, 2'b01, {5'd0, 5'd5}, 1'b1, 5'd6, 1'b0);
        tbRst = 1'b1;
        applyStimulus(2'b01, {5'd0, 5'd5}, {32'h0, 32'h5555}, 2'b11, {5'd6, 5'd5}, 1'b0, 5'd0, 1'b0);
        tbRst = 1'b0;
        applyStimulus(2'b01, {5'd0, 5'd5}, {32'h0, 32'h1}, 2'b00, '0, 1'b0, 5'd0, 1'b0);
        applyStimulus(2'b00, '0, '0, 2'b01, {5'd0, 5'd5}, 1'b0, 5'd0, 1'b0);

        // x0 is immune to writes and issues
        applyStimulus(2'b01, {5'd0, 5'd0}, {32'h0, 32'hFFFFFFFF}, 2'b01, {5'd0, 5'd0}, 1'b1, 5'd0, 1'b0);
        applyStimulus(2'b00, '0, '0, 2'b11, {5'd0, 5'd0}, 1'b0, 5'd0, 1'b0);

        // bypass versus stored value on x7
        applyStimulus(2'b01, {5'd0, 5'd7}, {32'h0, 32'h11}, 2'b00, '0, 1'b0, 5'd0, 1'b0);
        applyStimulus(2'b10, {5'd7, 5'd0}, {32'h22, 32'h0}, 2'b10, {5'd7, 5'd0}, 1'b0, 5'd0, 1'b0);
        applyStimulus(2'b00, '0, '0, 2'b11, {5'd7, 5'd7}, 1'b0, 5'd0, 1'b0);

        // dual-lane collision on x3, read during and after
        applyStimulus(2'b11, {5'd3, 5'd3}, {32'hB, 32'hA}, 2'b01, {5'd0, 5'd3}, 1'b0, 5'd0, 1'b0);
        applyStimulus(2'b00, '0, '0, 2'b01, {5'd0, 5'd3}, 1'b0, 5'd0, 1'b0);

        // scoreboard on x9
        applyStimulus(2'b00, '0, '0, 2'b00, '0, 1'b1, 5'd9, 1'b0);
        applyStimulus(2'b00, '0, '0, 2'b01, {5'd0, 5'd9}, 1'b0, 5'd0, 1'b0);
        applyStimulus(2'b01, {5'd0, 5'd9}, {32'h0, 32'h99}, 2'b00, '0, 1'b1, 5'd9, 1'b0);
        applyStimulus(2'b00, '0, '0, 2'b01, {5'd0, 5'd9}, 1'b0, 5'd0, 1'b0);
        applyStimulus(2'b01, {5'd0, 5'd9}, {32'h0, 32'h9A}, 2'b00, '0, 1'b0, 5'd0, 1'b0);
        applyStimulus(2'b00, '0, '0, 2'b01, {5'd0, 5'd9}, 1'b0, 5'd0, 1'b0);

        // flush with simultaneous issue leaves only x4 busy
        applyStimulus(2'b00, '0, '0, 2'b00, '0, 1'b1, 5'd1, 1'b0);
        applyStimulus(2'b00, '0, '0, 2'b00, '0, 1'b1, 5'd2, 1'b0);
        applyStimulus(2'b00, '0, '0, 2'b11, {5'd2, 5'd1}, 1'b1, 5'd3, 1'b0);
        applyStimulus(2'b00, '0, '0, 2'b00, '0, 1'b1, 5'd4, 1'b1);
        applyStimulus(2'b00, '0, '0, 2'b11, {5'd2, 5'd1}, 1'b0, 5'd0, 1'b0);
        applyStimulus(2'b00, '0, '0, 2'b11, {5'd4, 5'd3}, 1'b0, 5'd0, 1'b0);

        for (int c = 0; c < 400; c++) begin
            tbRst   = ($urandom_range(0, 149) == 0);
            rWe     = NW'($urandom_range(0, 3));
            rWreg   = {randReg(), randReg()};
            rWdata  = {$urandom, $urandom};
            rRe     = NR'($urandom_range(0, 3));
            rRreg   = {randReg(), randReg()};
            rIss    = ($urandom_range(0, 2) == 0);
            rIssReg = randReg();
            rFlush  = ($urandom_range(0, 15) == 0);
            applyStimulus(rWe, rWreg, rWdata, rRe, rRreg, rIss, rIssReg, rFlush);
        end
        tbRst = 1'b0;

        @(posedge clk);
        #1;
        rst = 1'b0;
        busB.i_read_en = '0; busB.i_write_en = '0; busB.i_issue_en = 1'b0; busB.i_flush = 1'b0;
        busN.i_read_en = '0; busN.i_write_en = '0; busN.i_issue_en = 1'b0; busN.i_flush = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file for the next core generation.
- Provides NR combinational read ports and NW write ports (writeback lanes).
- Optional same-cycle write-to-read bypass.
- Per-register busy scoreboard: set when an instruction issues with a destination register, cleared at writeback. Decode uses it for RAW-hazard stalls; hardwired-zero x0.

Parameters:
- DW, 32, data width.
- RAW, 5, register address width; depth DP = 2**RAW.
- NR, 2, number of read ports (1..4).
- NW, 2, number of write ports (1..2).
- BYPASS, 1, 1 = a write in the current cycle is forwarded to matching reads in the same cycle.
- ZERO_REG, 1, 1 = register 0 reads 0, is never written and is never busy.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- i_write_en  in  NW  per-lane write enable.
- i_write_reg  in  NW*RAW  per-lane destination; lane k = bits [k*RAW +: RAW].
- i_write_data  in  NW*DW  per-lane write data.
- i_read_en  in  NR  per-port read enable.
- i_read_reg  in  NR*RAW  per-port source register.
- o_read_data  out  NR*DW  per-port read data.
- o_read_busy  out  NR  per-port busy flag: source has a pending write.
- i_issue_en  in  1  set the busy bit for i_issue_reg.
- i_issue_reg  in  RAW  destination register being issued.
- i_flush  in  1  clear all busy bits (pipeline flush).
- o_idle  out  1  no busy bits set.

Behaviour:
Reset (asynchronous assert, synchronous-safe deassert):
- All DP registers = 0 and all busy bits = 0.
- Outputs while rst is high: o_read_data = 0, o_read_busy = 0, o_idle = 1.

Writes:
- On rising clk, each lane with i_write_en=1 stores its data to i_write_reg and clears busy[i_write_reg].
- With ZERO_REG=1, writes to reg 0 are ignored.
- Two lanes hitting the same register in one cycle: the highest-index lane wins for both data and busy clear.

Reads (combinational, zero latency):
- Port disabled, or reg=0 with ZERO_REG=1: data 0, busy 0.
- Otherwise, if BYPASS=1 and any enabled write lane targets the same register this cycle: data = that lane's write data (highest lane wins) and busy = 0.
- Otherwise: data = stored value, busy = busy[reg].
- With BYPASS=0: reads return the stored (pre-edge) value and busy[reg] unchanged.

Scoreboard update order within one clock edge:
1. Writeback clears.
2. i_flush clears all bits.
3. i_issue_en sets busy[i_issue_reg].

Consequences:
- Issue and writeback to the same register in the same cycle leave busy = 1 (the new producer is pending).
- Flush plus issue in the same cycle leaves exactly one bit set.
- Issue to reg 0 with ZERO_REG=1 is ignored.
- Re-issuing an already-busy register keeps it busy (no counting).
- Writes to a non-busy register are legal and simply update data.

o_idle: registered-state NOR of all busy bits; reflects state after the last edge.

Widths:
- All read data is exactly DW bits; no sign extension.
- Address decoding uses all RAW bits; every index 0..DP-1 is valid.

Test Plan:
- Reset then read: assert rst mid-run after writing x5=32'hDEADBEEF → x5 reads 0 immediately (async), o_idle=1; after deassert, write x5=1 → next cycle reads 1.
- x0 protection: write lane0 reg0=32'hFFFFFFFF, issue reg0 → port0 read reg0 = 0, busy 0, o_idle stays 1.
- Bypass: BYPASS=1, x7 stored 32'h11; same cycle lane1 writes x7=32'h22 and port1 reads x7 → o_read_data port1 = 32'h22 that cycle. With BYPASS=0 → 32'h11 that cycle, 32'h22 next cycle.
- Dual-write collision: lane0 x3=32'hA, lane1 x3=32'hB same cycle → x3 = 32'hB afterwards.
- Scoreboard: issue x9 → next cycle port0 read x9 busy=1, o_idle=0. Lane0 writes x9 and issue x9 in the same cycle → busy stays 1. Write x9 alone → busy 0, o_idle=1.
- Flush: issue x1, x2, x3 over three cycles, then i_flush with i_issue_reg=x4 → only x4 busy; reads of x1..x3 report busy 0.
